// File: rtl/pe_agu_ctrl_pkg.sv
// Shared types and constants for the PE AGU sequencer and its helpers.
package pe_agu_ctrl_pkg;

    localparam int unsigned MODE_W     = 2;
    localparam int unsigned IDX_CNT_W  = 8;
    localparam int unsigned TRIP_CNT_W = 8;
    localparam int unsigned PAD_W      = 4;

    localparam logic [MODE_W-1:0] MODE_CONV    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FC      = 2'b01;
    localparam logic [MODE_W-1:0] MODE_CONV_BP = 2'b10;
    localparam logic [MODE_W-1:0] MODE_FC_BP   = 2'b11;

    // Instruction payload handed to the AGU, held stable while it runs
    typedef struct packed {
        logic [MODE_W-1:0]     mode;
        logic [IDX_CNT_W-1:0]  idx_cnt;
        logic [TRIP_CNT_W-1:0] trip_cnt;
        logic                  is_new;
        logic [PAD_W-1:0]      pad_code;
        logic                  cut_y;
    } agu_ins_t;

endpackage

// File: rtl/pe_agu_ctrl_idx_pp_tracker.sv
// Ping-pong index buffer bookkeeping: write-half full, read-half valid,
// and a sticky overflow flag when a load lands on an already full half.
module pe_agu_ctrl_idx_pp_tracker
    import pe_agu_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_done,
    input  logic swap,
    output logic wr_full,
    output logic rd_valid,
    output logic wr_free,
    output logic err_ovf
);

    logic wr_full_n;

    // A load coincident with a swap refills the freshly freed half
    always_comb begin
        wr_full_n = load_done | (wr_full & ~swap);
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_full  <= 1'b0;
            rd_valid <= 1'b0;
            wr_free  <= 1'b1;
            err_ovf  <= 1'b0;
        end else begin
            wr_full <= wr_full_n;
            wr_free <= ~wr_full_n;
            if (swap) begin
                rd_valid <= 1'b1;
            end
            if (load_done && wr_full && !swap) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_agu_ctrl.sv
// Per-PE sequencer feeding pe_agu: accepts one instruction at a time,
// swaps the index ping-pong buffer when needed, starts the AGU and waits
// for its done. Define PE_AGU_CTRL_PERF_EN to add stall/run counters.
module pe_agu_ctrl
    import pe_agu_ctrl_pkg::*;
#(
    parameter int unsigned GRP_ID_X = 0,
    parameter int unsigned GRP_ID_Y = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [MODE_W-1:0]     ins_mode,
    input  logic [IDX_CNT_W-1:0]  ins_idx_cnt,
    input  logic [TRIP_CNT_W-1:0] ins_trip_cnt,
    input  logic                  ins_is_new,
    input  logic [PAD_W-1:0]      ins_pad_code,
    input  logic                  ins_cut_y,
    input  logic                  ins_reuse_idx,
    input  logic                  idx_load_done,
    output logic                  idx_wr_free,
    output logic                  switch_idx_buf,
    output logic                  agu_start,
    output logic [MODE_W-1:0]     agu_mode,
    output logic [IDX_CNT_W-1:0]  agu_idx_cnt,
    output logic [TRIP_CNT_W-1:0] agu_trip_cnt,
    output logic                  agu_is_new,
    output logic [PAD_W-1:0]      agu_pad_code,
    output logic                  agu_cut_y,
    input  logic                  agu_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      ins_done_cnt,
    output logic                  err_ovf
`ifdef PE_AGU_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_idx_cnt,
    output logic [CNT_W-1:0]      run_cyc_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SWITCH,
        START,
        ARM,
        RUN,
        FIN
    } state_t;

    // Group id kept visible as a debug tag only
    localparam logic [15:0] GRP_TAG = {GRP_ID_Y[7:0], GRP_ID_X[7:0]};
    logic [15:0] grp_tag_unused;
    assign grp_tag_unused = GRP_TAG;

    state_t   state, state_n;
    agu_ins_t cfg;
    logic     reuse_q;
    logic     wr_full, rd_valid;
    logic     accept;
    logic     ins_ready_n, switch_n, start_n, busy_n;

    assign accept = ins_valid & ins_ready;

    assign agu_mode     = cfg.mode;
    assign agu_idx_cnt  = cfg.idx_cnt;
    assign agu_trip_cnt = cfg.trip_cnt;
    assign agu_is_new   = cfg.is_new;
    assign agu_pad_code = cfg.pad_code;
    assign agu_cut_y    = cfg.cut_y;

    // Index half tracking; the registered swap pulse is what the buffer sees
    pe_agu_ctrl_idx_pp_tracker u_idx_pp (
        .clk       (clk),
        .rst       (rst),
        .load_done (idx_load_done),
        .swap      (switch_idx_buf),
        .wr_full   (wr_full),
        .rd_valid  (rd_valid),
        .wr_free   (idx_wr_free),
        .err_ovf   (err_ovf)
    );

    // Next state; outputs are registered copies decoded from the next state
    always_comb begin
        state_n     = state;
        ins_ready_n = 1'b0;
        switch_n    = 1'b0;
        start_n     = 1'b0;
        busy_n      = 1'b0;
        case (state)
            IDLE:   if (accept) state_n = CHECK;
            CHECK: begin
                if (reuse_q && rd_valid) begin
                    state_n = START;
                end else if (wr_full) begin
                    state_n = SWITCH;
                end
            end
            SWITCH: state_n = START;
            START:  state_n = ARM;
            ARM:    state_n = RUN;     // done may still show the previous level
            RUN:    if (agu_done) state_n = FIN;
            FIN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ins_ready_n = (state_n == IDLE);
        switch_n    = (state_n == SWITCH);
        start_n     = (state_n == START);
        busy_n      = (state_n != IDLE);
    end

    // State, handshake outputs, latched config and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ins_ready      <= 1'b0;
            switch_idx_buf <= 1'b0;
            agu_start      <= 1'b0;
            busy           <= 1'b0;
            cfg            <= '0;
            reuse_q        <= 1'b0;
            ins_done_cnt   <= '0;
        end else begin
            state          <= state_n;
            ins_ready      <= ins_ready_n;
            switch_idx_buf <= switch_n;
            agu_start      <= start_n;
            busy           <= busy_n;
            if (accept) begin
                cfg     <= '{mode: ins_mode, idx_cnt: ins_idx_cnt,
                             trip_cnt: ins_trip_cnt, is_new: ins_is_new,
                             pad_code: ins_pad_code, cut_y: ins_cut_y};
                reuse_q <= ins_reuse_idx;
            end
            if (state == FIN) begin
                ins_done_cnt <= ins_done_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PE_AGU_CTRL_PERF_EN
    logic stall_c;
    logic run_c;

    assign stall_c = (state == CHECK) && !(reuse_q && rd_valid) && !wr_full;
    assign run_c   = (state == ARM) || (state == RUN);

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_idx_cnt <= '0;
            run_cyc_cnt   <= '0;
        end else begin
            if (stall_c && (stall_idx_cnt != '1)) begin
                stall_idx_cnt <= stall_idx_cnt + CNT_W'(1);
            end
            if (run_c && (run_cyc_cnt != '1)) begin
                run_cyc_cnt <= run_cyc_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
